ship_draw: RTL
==============

# ship_draw

Pixel-stream renderer for one 10×10 battleship board. It sits in the VGA draw chain and owns a 2-bit state per board cell. From the incoming raster position it builds the 7-bit sprite-ROM address, then turns the returned 32-bit sprite line into the output pixel colour. All VGA timing signals are re-aligned to the pipeline latency.

## Interface
- XPOS, 64: board left edge, pixels
- YPOS, 64: board top edge, pixels
- CELLS, 10: cells per side (max 16)
- COLOR_SHIP, 12'h888: colour for set bits in ship state
- COLOR_HIT, 12'hF00: colour for set bits in hit state
- COLOR_MISS, 12'h00F: colour for set bits in miss state
- COLOR_GRID, 12'hFFF: grid line colour (macro-dependent)
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- vcount_in, hcount_in  in  11 each  raster position
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  VGA timing
- rgb_in  in  12  background pixel
- cell_we  in  1  cell write strobe
- cell_wx, cell_wy  in  4 each  write coordinates
- cell_wstate  in  2  0 empty, 1 ship, 2 hit, 3 miss
- board_clr  in  1  clear all cells to empty
- rom_addr  out  7  sprite ROM address {state[1:0], 1'b0, row[3:0]}
- rom_data  in  32  sprite line from ROM; registered, valid 1 clk after rom_addr
- vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out  out  11/11/1/1/1/1  delayed timing
- rgb_out  out  12  rendered pixel

## Operation
- Cell store: CELLS×CELLS array of 2-bit states. Reset and board_clr set every cell to 0.
- Write: on cell_we with cell_wx<CELLS and cell_wy<CELLS, the cell takes cell_wstate. Out-of-range writes are ignored.
- board_clr and cell_we in the same cycle: clear wins and the write is dropped.
- Read-during-write of the same cell returns the old state. The new state is visible from the next cycle.
- Board geometry: dx = hcount_in − XPOS, dy = vcount_in − YPOS, both unsigned 11-bit. in_board = hcount_in ≥ XPOS && dx < CELLS·32 && vcount_in ≥ YPOS && dy < CELLS·32.
- Cell mapping: cell = (dx[8:5], dy[8:5]). Sprite row = dy[4:1], so each ROM line is shown twice and the cell is 32×32. Sprite column = dx[4:0]; bit index = 31 − column, MSB leftmost.
- Outside the board, rom_addr uses state 0 and the pixel passes through.
- Pixel select when in_board && !vblnk && !hblnk and the selected bit = 1:
  - state 1 → COLOR_SHIP
  - state 2 → COLOR_HIT
  - state 3 → COLOR_MISS
  - state 0, or bit = 0 → the delayed rgb_in.
- Blanked or off-board pixels output the delayed rgb_in unchanged.

## Timing
- Stage 1 (edge 1): compute in_board, column and cell; look up state. Register rom_addr and the stage-1 copies of the timing signals and rgb.
- Stage 2 (edge 2): the ROM registers rom_data. In parallel, stage-2 copies of in_board, column, state, timing and rgb are registered.
- Stage 3 (edge 3): all outputs registered from rom_data plus the stage-2 copies.
- Latency: input to every output = 3 clk, including the timing signals and rgb.
- Latency: input to rom_addr = 1 clk.
- Reset: every output and pipeline register is 0, including rom_addr = 7'h00 and rgb_out = 0. Cells are cleared.
- Reset asserted mid-frame: the pipeline flushes to 0 immediately. The first valid output appears 3 clk after rst deasserts.
- No stalls or backpressure: one pixel per clk.
- hcount wrap at line end needs no special handling; each pixel is independent.

## Configuration
- SHIP_DRAW_GRID_EN defined:
  - when in_board and dx[4:0]==0 or dy[4:0]==0, rgb_out = COLOR_GRID;
  - this overrides the sprite colour;
  - it is aligned in the same 3-clk pipeline.
- Undefined: no grid logic and no grid override. COLOR_GRID stays a parameter but is unused.

## Test plan
- After reset, sweep a full frame with rgb_in=12'h0A0 and an all-empty board → rom_addr[6:5]=0 everywhere; rgb_out=12'h0A0 on every active pixel, 3 clk delayed (grid macro off).
- Write (2,3)=ship and model the ROM at 1-clk latency, then raster the pixel hcount=XPOS+64+5, vcount=YPOS+96+7 → rom_addr=7'h23 one clk later; rgb_out=12'h888 three clk later.
- Write (0,0)=hit, then read at dx=3, dy=2 (ROM row 1 = F38001CF, bit 28 = 1) → COLOR_HIT. At dx=4 (bit 27 = 0) → rgb_in passthrough.
- Pulse cell_we (9,9)=miss and board_clr in the same cycle → cell (9,9) stays empty. A write to (10,0) is ignored and the board is unchanged.
- Assert rst while the pipeline is full → all outputs read 0 within the same cycle. After release, outputs track the inputs with 3-clk latency.
- With SHIP_DRAW_GRID_EN defined, pixel at dx=32, dy=17 → rgb_out=12'hFFF. Without the macro, the same pixel shows the sprite or background value.

Source files
------------

// File: rtl/ship_draw.sv
// rtl/ship_draw.sv - battleship board pixel renderer, 3-clk pipeline (optional grid overlay: SHIP_DRAW_GRID_EN)
module ship_draw #(
  parameter int          XPOS       = 64,
  parameter int          YPOS       = 64,
  parameter int          CELLS      = 10,
  parameter logic [11:0] COLOR_SHIP = 12'h888,
  parameter logic [11:0] COLOR_HIT  = 12'hF00,
  parameter logic [11:0] COLOR_MISS = 12'h00F,
  parameter logic [11:0] COLOR_GRID = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        cell_we,
  input  logic [3:0]  cell_wx,
  input  logic [3:0]  cell_wy,
  input  logic [1:0]  cell_wstate,
  input  logic        board_clr,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam int          IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [10:0] X0    = 11'(XPOS);
  localparam logic [10:0] Y0    = 11'(YPOS);
  localparam logic [10:0] SPAN  = 11'(CELLS * 32);
  localparam logic [4:0]  NCELL = 5'(CELLS);

  // cell store, indexed [row][column]
  logic [1:0] cells [CELLS][CELLS];

  logic [10:0] dx, dy;
  logic        in_board;
  logic [1:0]  cur_state;
  logic        wr_ok;

  // stage 1 registers
  logic        s1_in;
  logic [4:0]  s1_col;
  logic [1:0]  s1_state;
  logic [10:0] s1_h, s1_v;
  logic        s1_vs, s1_hs, s1_vb, s1_hb;
  logic [11:0] s1_rgb;

  // stage 2 registers
  logic        s2_in;
  logic [4:0]  s2_col;
  logic [1:0]  s2_state;
  logic [10:0] s2_h, s2_v;
  logic        s2_vs, s2_hs, s2_vb, s2_hb;
  logic [11:0] s2_rgb;

  logic [11:0] pix;
  logic        sel_bit;

`ifdef SHIP_DRAW_GRID_EN
  logic grid_hit;
  logic s1_grid, s2_grid;
`else
  logic unused_color_grid;
  assign unused_color_grid = ^COLOR_GRID;
`endif

  // board geometry and cell lookup; the stored state is read before this edge's write lands
  always_comb begin
    dx        = hcount_in - X0;
    dy        = vcount_in - Y0;
    in_board  = (hcount_in >= X0) && (dx < SPAN) && (vcount_in >= Y0) && (dy < SPAN);
    cur_state = 2'd0;
    if (in_board) begin
      cur_state = cells[dy[5+IW-1:5]][dx[5+IW-1:5]];
    end
    wr_ok = cell_we && ({1'b0, cell_wx} < NCELL) && ({1'b0, cell_wy} < NCELL);
  end

`ifdef SHIP_DRAW_GRID_EN
  // grid lines fall on the first pixel row/column of each cell
  always_comb begin
    grid_hit = in_board && ((dx[4:0] == 5'd0) || (dy[4:0] == 5'd0));
  end
`endif

  // cell array: clear has priority over a simultaneous write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        for (int j = 0; j < CELLS; j++) begin
          cells[i][j] <= 2'd0;
        end
      end
    end else if (board_clr) begin
      for (int i = 0; i < CELLS; i++) begin
        for (int j = 0; j < CELLS; j++) begin
          cells[i][j] <= 2'd0;
        end
      end
    end else if (wr_ok) begin
      cells[cell_wy[IW-1:0]][cell_wx[IW-1:0]] <= cell_wstate;
    end
  end

  // stage 1: sprite address plus first copy of the pixel context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= 7'd0;
      s1_in    <= 1'b0;
      s1_col   <= 5'd0;
      s1_state <= 2'd0;
      s1_h     <= 11'd0;
      s1_v     <= 11'd0;
      s1_vs    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vb    <= 1'b0;
      s1_hb    <= 1'b0;
      s1_rgb   <= 12'd0;
    end else begin
      rom_addr <= {cur_state, 1'b0, dy[4:1]};
      s1_in    <= in_board;
      s1_col   <= dx[4:0];
      s1_state <= cur_state;
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
      s1_vs    <= vsync_in;
      s1_hs    <= hsync_in;
      s1_vb    <= vblnk_in;
      s1_hb    <= hblnk_in;
      s1_rgb   <= rgb_in;
    end
  end

  // stage 2: context held in step with the ROM's own output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_in    <= 1'b0;
      s2_col   <= 5'd0;
      s2_state <= 2'd0;
      s2_h     <= 11'd0;
      s2_v     <= 11'd0;
      s2_vs    <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vb    <= 1'b0;
      s2_hb    <= 1'b0;
      s2_rgb   <= 12'd0;
    end else begin
      s2_in    <= s1_in;
      s2_col   <= s1_col;
      s2_state <= s1_state;
      s2_h     <= s1_h;
      s2_v     <= s1_v;
      s2_vs    <= s1_vs;
      s2_hs    <= s1_hs;
      s2_vb    <= s1_vb;
      s2_hb    <= s1_hb;
      s2_rgb   <= s1_rgb;
    end
  end

`ifdef SHIP_DRAW_GRID_EN
  // grid flag rides the same pipeline as the pixel it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= grid_hit;
      s2_grid <= s1_grid;
    end
  end
`endif

  // colour select: sprite bit 31 is the leftmost pixel of the line
  always_comb begin
    pix     = s2_rgb;
    sel_bit = rom_data[~s2_col];
    if (s2_in && !s2_vb && !s2_hb) begin
      if (sel_bit) begin
        case (s2_state)
          2'd1:    pix = COLOR_SHIP;
          2'd2:    pix = COLOR_HIT;
          2'd3:    pix = COLOR_MISS;
          default: pix = s2_rgb;
        endcase
      end
`ifdef SHIP_DRAW_GRID_EN
      if (s2_grid) begin
        pix = COLOR_GRID;
      end
`endif
    end
  end

  // stage 3: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= s2_h;
      vcount_out <= s2_v;
      vsync_out  <= s2_vs;
      hsync_out  <= s2_hs;
      vblnk_out  <= s2_vb;
      hblnk_out  <= s2_hb;
      rgb_out    <= pix;
    end
  end

endmodule
